// File: rtl/mux_16x1_reg_pkg.sv
// Shared constants and types for the 16:1 registered lane selector.
package mux_pkg;

  localparam int MUX_N_IN  = 16;
  localparam int MUX_SEL_W = 4;

  typedef logic [MUX_SEL_W-1:0] mux_sel_t;

endpackage

// File: rtl/mux_16x1_reg_if.sv
// Bus bundle for mux_16x1_reg: packed lanes, select and enable in; registered lane out.
// MUX_COMB_BYPASS_EN adds the zero-latency y_comb output.
interface mux_16x1_reg_if
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic [MUX_N_IN*DATA_W-1:0] a;
  mux_sel_t                   sel;
  logic                       en;
  logic [DATA_W-1:0]          y;
  logic                       y_vld;
`ifdef MUX_COMB_BYPASS_EN
  logic [DATA_W-1:0]          y_comb;
`endif

`ifdef MUX_COMB_BYPASS_EN
  modport master (output a, sel, en, input y, y_vld, y_comb);
  modport slave  (input a, sel, en, output y, y_vld, y_comb);
`else
  modport master (output a, sel, en, input y, y_vld);
  modport slave  (input a, sel, en, output y, y_vld);
`endif

endinterface

// File: rtl/mux_16x1_reg_tree.sv
// Combinational 16:1 selector built as four levels of 2:1 muxes; level i is steered by sel_i[i].
module mux_2x1_tree_16
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [MUX_N_IN*DATA_W-1:0] a_i,
  input  mux_sel_t                   sel_i,
  output logic [DATA_W-1:0]          y_o
);

  logic [DATA_W-1:0] lvl0 [8];
  logic [DATA_W-1:0] lvl1 [4];
  logic [DATA_W-1:0] lvl2 [2];

  for (genvar k = 0; k < 8; k++) begin : g_lvl0
    assign lvl0[k] = sel_i[0] ? a_i[(2*k+1)*DATA_W +: DATA_W]
                              : a_i[(2*k)*DATA_W   +: DATA_W];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lvl1
    assign lvl1[k] = sel_i[1] ? lvl0[2*k+1] : lvl0[2*k];
  end

  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    assign lvl2[k] = sel_i[2] ? lvl1[2*k+1] : lvl1[2*k];
  end

  assign y_o = sel_i[3] ? lvl2[1] : lvl2[0];

endmodule

// File: rtl/mux_16x1_reg.sv
// 16:1 lane selector with registered output and a one-cycle valid strobe.
// Optional MUX_COMB_BYPASS_EN exposes the unregistered selection as y_comb.
module mux_16x1_reg
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_16x1_reg_if.slave  bus
);

  logic [DATA_W-1:0] next_y;
  logic [DATA_W-1:0] y_d, y_q;
  logic              vld_d, vld_q;

  mux_2x1_tree_16 #(.DATA_W(DATA_W)) u_tree (
    .a_i   (bus.a),
    .sel_i (bus.sel),
    .y_o   (next_y)
  );

  // y holds when disabled; valid only marks cycles that followed an enabled edge
  always_comb begin
    y_d   = bus.en ? next_y : y_q;
    vld_d = bus.en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.y_vld = vld_q;

`ifdef MUX_COMB_BYPASS_EN
  assign bus.y_comb = next_y;
`endif

endmodule

// File: tb/tb_mux_16x1_reg.sv
// Self-checking bench for mux_16x1_reg: directed plan plus random traffic against a lane-shift model.
module tb_mux_16x1_reg;
  import mux_pkg::*;

  localparam int DW = 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [15:0] m_a;
  logic [3:0]  m_sel;
  logic [DW-1:0] exp_y;
  logic          exp_vld;

  mux_16x1_reg_if #(.DATA_W(DW)) bus ();

  mux_16x1_reg #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected lane is the sel-th DW-bit field of a.
  function automatic logic [DW-1:0] lane_of(input logic [15:0] a, input int s);
    logic [15:0] sh;
    sh = a >> (s * DW);
    return sh[DW-1:0];
  endfunction

  task automatic check(input string tag);
    total++;
    assert (bus.y === exp_y) else begin
      bad++;
      $error("FAIL %s y: got %0h want %0h", tag, bus.y, exp_y);
    end
    total++;
    assert (bus.y_vld === exp_vld) else begin
      bad++;
      $error("FAIL %s y_vld: got %0b want %0b", tag, bus.y_vld, exp_vld);
    end
  endtask

  task automatic step(input logic [15:0] a, input int s, input logic e, input string tag);
    @(negedge clk);
    bus.a   = a;
    bus.sel = 4'(s);
    bus.en  = e;
`ifdef MUX_COMB_BYPASS_EN
    #1;
    total++;
    assert (bus.y_comb === lane_of(a, s)) else begin
      bad++;
      $error("FAIL %s y_comb: got %0h want %0h", tag, bus.y_comb, lane_of(a, s));
    end
`endif
    if (e) exp_y = lane_of(a, s);
    exp_vld = e;
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.a   = '0;
    bus.sel = '0;
    bus.en  = 1'b0;
    exp_y   = '0;
    exp_vld = 1'b0;

    @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(16'h0000, 0, 1'b1, "idle_zero");

    for (int s = 0; s < 16; s++) begin
      step(16'h0001 << s, s, 1'b1, "walk_one_hit");
      step(16'h0001 << s, (s + 1) % 16, 1'b1, "walk_one_miss");
    end

    for (int s = 0; s < 16; s++)
      step(~(16'h0001 << s), s, 1'b1, "all_but_sel");

    m_a = 16'(32'h0001 << 16);
    step(m_a, 15, 1'b1, "shift_out_15");
    step(m_a, 0, 1'b1, "shift_out_wrap0");
    step(16'h0001, 0, 1'b1, "lane0_one");

    step(16'h0001, 0, 1'b1, "hold_load");
    for (int i = 0; i < 3; i++)
      step(16'h0000, 0, 1'b0, "hold_idle");
    step(16'h0000, 0, 1'b1, "hold_release");

    // Asynchronous reset in the middle of a cycle with y previously 1.
    step(16'h0100, 8, 1'b1, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    exp_y   = '0;
    exp_vld = 1'b0;
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h4000, 14, 1'b1, "post_reset");

    for (int i = 0; i < 300; i++) begin
      m_a   = 16'($urandom);
      m_sel = 4'($urandom_range(0, 15));
      step(m_a, int'(m_sel), 1'($urandom_range(0, 3) != 0), "random");
    end

    // Toggling every lane except the selected one must leave y alone.
    for (int s = 0; s < 16; s++) begin
      m_a = 16'($urandom);
      step(m_a, s, 1'b1, "unsel_base");
      step(m_a ^ ~(16'h0001 << s), s, 1'b1, "unsel_toggle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_16x1_reg.md
Name: mux_16x1_reg

Overview:
- 16-to-1 data selector with a registered output. One of 16 input lanes is chosen by a 4-bit select and delivered to the output one clock later.
- Used as a generic lane picker in datapaths that need a clean registered output.
- Default configuration is 16 single-bit lanes.

Parameters:
- DATA_W, 1, width in bits of each input lane and of the output.
- N_IN, 16, number of input lanes; fixed at 16 and not to be overridden.
- SEL_W, 4, select width; equals clog2(N_IN).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  N_IN*DATA_W  packed input lanes; lane k occupies bits [k*DATA_W +: DATA_W]; lane 0 is the LSBs.
- sel  input  SEL_W  lane select, unsigned.
- en  input  1  output register update enable.
- y  output  DATA_W  registered selected lane.
- y_vld  output  1  high one cycle after a cycle with en=1.

Interface note: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: while rst_n=0, y=0 and y_vld=0 immediately, without waiting for a clock edge. On deassertion, the registers update at the first rising clk edge.
- Selection function: next_y = a[sel*DATA_W +: DATA_W]. This is purely combinational from a and sel.
- Every sel value 0..15 is legal. There is no out-of-range case and no default-to-zero path is needed for legal values.
- Latency: on a rising clk edge with en=1, y <= next_y and y_vld <= 1.
- Hold: on a rising clk edge with en=0, y holds its value and y_vld <= 0.
- No data dependency between cycles; a and sel may change every cycle.
- Select wrap: sel incrementing from 15 to 0 selects lane 0 on the next registration, with no glitch state.
- Unselected lanes: changes on unselected lanes never affect y.
- Reset mid-operation: assertion clears y and y_vld asynchronously. The first enabled edge after release registers the current selection.
- X handling: if sel contains X/Z, simulation may propagate X. Synthesis requires no special handling.

Optional Feature:
- Macro: MUX_COMB_BYPASS_EN.
- When defined: adds output port y_comb (DATA_W), equal to next_y combinationally with zero latency and unaffected by en or rst_n. The registered y behaves identically.
- When undefined: the y_comb port does not exist and the only output path is registered.

Decomposition:
- Package mux_pkg holds:
  - localparam MUX_N_IN = 16 and MUX_SEL_W = 4;
  - typedef mux_sel_t (logic [MUX_SEL_W-1:0]).
- Sub-module mux_2x1_tree_16 is a natural split: a purely combinational 4-level binary tree of 2:1 muxes, parameterized by DATA_W, producing next_y.
  - Level i is steered by sel[i].
  - The top level wraps it with the output and valid registers.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with y previously 1 -> y=0 and y_vld=0 immediately, before the next clk edge.
- Idle zero: a=16'h0000, sel=0, en=1 -> y=0 and y_vld=1 one cycle later.
- Walking one: for sel=0..15 apply a=16'h0001<<sel, en=1 -> y=1 one cycle later for every sel. With the same a and sel+1 applied, y=0 (lane mismatch).
- All-ones except selected lane: a=~(16'h0001<<sel) for all sel -> y=0 each time, proving the correct lane is chosen rather than an OR of lanes.
- Shifted-out zero and wrap: a=16'h0001<<16 (=0) with sel wrapping 15->0 -> y=0. Then a=16'h0001, sel=0 -> y=1.
- Enable hold: register y=1 with en=1, then set a=0 with en=0 for 3 cycles -> y stays 1 and y_vld=0. Re-assert en -> y=0 next cycle.
